// File: rtl/neural_pkg.sv
// Shared types, default sizing and accumulator-width helper for the neuron MAC.
package neural_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_FRAC  = 8;
  localparam int unsigned DEF_N_IN  = 4;

  // Each shifted product carries 2*width-frac significant bits; summing n_in of
  // them plus a narrower bias needs clog2(n_in)+1 guard bits to never overflow.
  function automatic int unsigned acc_width(input int unsigned width,
                                            input int unsigned frac,
                                            input int unsigned n_in);
    int unsigned guard;
    guard = (n_in > 1) ? $clog2(n_in) : 32'd0;
    return 2 * width - frac + guard + 1;
  endfunction

endpackage

// File: rtl/neural_fix_mul.sv
// Signed fixed-point multiply, arithmetic shift right by FRAC (floor rounding).
module neural_fix_mul #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned FRAC  = 8
) (
  input  logic signed [WIDTH-1:0]        x_i,
  input  logic signed [WIDTH-1:0]        w_i,
  output logic signed [2*WIDTH-FRAC-1:0] prod_c_o
);

  localparam int unsigned PW = 2 * WIDTH - FRAC;

  logic signed [2*WIDTH-1:0] full_c;

  // Full-precision product, then drop FRAC fraction bits toward minus infinity.
  always_comb begin
    full_c   = x_i * w_i;
    prod_c_o = PW'(full_c >>> FRAC);
  end

endmodule

// File: rtl/neural_mac_unit.sv
// Neuron evaluation: bias + sum of N_IN fixed-point products, step activation.
// Optional macro NEURAL_SAT_EN: saturate the final sum to WIDTH bits instead of
// wrapping.
module neural_mac_unit
  import neural_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned FRAC  = DEF_FRAC,
  parameter int unsigned N_IN  = DEF_N_IN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] bias,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_w,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_fire,
  output logic             busy
);

  localparam int unsigned PW    = 2 * WIDTH - FRAC;
  localparam int unsigned ACC_W = acc_width(WIDTH, FRAC, N_IN);
  localparam int unsigned CNT_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_IN - 1);

  state_e                  state_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic [CNT_W-1:0]        cnt_q;
  logic [WIDTH-1:0]        out_sum_q;
  logic                    out_fire_q;
  logic signed [PW-1:0]    prod_c;
  logic [WIDTH-1:0]        sum_c;
  logic                    fire_c;
  logic                    beat_c;

  neural_fix_mul #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_fix_mul (
    .x_i      (in_x),
    .w_i      (in_w),
    .prod_c_o (prod_c)
  );

  // Next accumulator value and its WIDTH-bit reduction for the final beat.
  always_comb begin
    beat_c = in_valid && (state_q == ST_ACCUM);
    acc_d  = acc_q + ACC_W'(prod_c);
    sum_c  = acc_d[WIDTH-1:0];
`ifdef NEURAL_SAT_EN
    if (acc_d[ACC_W-1:WIDTH-1] != {(ACC_W-WIDTH+1){acc_d[ACC_W-1]}}) begin
      sum_c = acc_d[ACC_W-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                             : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
    fire_c = !sum_c[WIDTH-1] && (|sum_c);
  end

  // Evaluation FSM: sample bias, accumulate N_IN beats, hold result until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      out_sum_q  <= '0;
      out_fire_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            acc_q   <= ACC_W'($signed(bias));
            cnt_q   <= '0;
            state_q <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (beat_c) begin
            acc_q <= acc_d;
            if (cnt_q == LAST_BEAT) begin
              cnt_q      <= '0;
              out_sum_q  <= sum_c;
              out_fire_q <= fire_c;
              state_q    <= ST_DONE;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Handshake and status flags decode directly from the state register.
  always_comb begin
    in_ready  = (state_q == ST_ACCUM);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q != ST_IDLE);
    out_sum   = out_sum_q;
    out_fire  = out_fire_q;
  end

endmodule

// File: tb/tb_neural_mac_unit.sv
// Directed self-checking bench for neural_mac_unit (WIDTH=16, FRAC=8, N_IN=4).
module tb_neural_mac_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] bias;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_x;
  logic [15:0] in_w;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_fire;
  logic        busy;

  int n_cmp;
  int n_fail;

  neural_mac_unit #(
    .WIDTH (16),
    .FRAC  (8),
    .N_IN  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bias      (bias),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_w      (in_w),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_fire  (out_fire),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start for one cycle; caller is aligned to a falling edge.
  task automatic do_start(input logic [15:0] b);
    start = 1'b1;
    bias  = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present one beat, waiting a bounded time for in_ready.
  task automatic send_beat(input logic [15:0] x, input logic [15:0] w);
    int guard;
    guard = 0;
    while (!in_ready && guard < 16) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 16) begin
      n_cmp++;
      n_fail++;
      $display("FAIL beat_wait: in_ready got %b want 1 within 16 cycles", in_ready);
    end
    in_valid = 1'b1;
    in_x     = x;
    in_w     = w;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Full evaluation with latency, result and hand-back checks.
  task automatic run_vector(input string name, input logic [15:0] b,
                            input logic [15:0] x, input logic [15:0] w,
                            input logic [15:0] exp_sum, input logic exp_fire);
    do_start(b);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s in_ready_accum: got %b want 1", name, in_ready);
    end
    for (int i = 0; i < 3; i++) send_beat(x, w);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s early_valid: got %b want 0", name, out_valid);
    end
    send_beat(x, w);
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s valid_latency: got %b want 1", name, out_valid);
    end
    n_cmp++;
    if (out_sum !== exp_sum) begin
      n_fail++;
      $display("FAIL %s out_sum: got %h want %h", name, out_sum, exp_sum);
    end
    n_cmp++;
    if (out_fire !== exp_fire) begin
      n_fail++;
      $display("FAIL %s out_fire: got %b want %b", name, out_fire, exp_fire);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s back_to_idle: got busy=%b valid=%b want 0/0", name, busy, out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, in_ready, out_valid, out_fire, out_sum} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 00000",
               {busy, in_ready, out_valid, out_fire, out_sum});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy got %b want 0", busy);
    end
  endtask

  task automatic test_basic();
    run_vector("bias0",    16'h0000, 16'h0100, 16'h0080, 16'h0200, 1'b1);
    run_vector("bias_m3",  16'hFD00, 16'h0100, 16'h0080, 16'hFF00, 1'b0);
    run_vector("bias_m2",  16'hFE00, 16'h0100, 16'h0080, 16'h0000, 1'b0);
    // (1 * -1) >> 8 floors to -1, four beats give -4.
    run_vector("floor",    16'h0000, 16'h0001, 16'hFFFF, 16'hFFFC, 1'b0);
  endtask

  task automatic test_overflow();
    // 127.0*127.0 = 0x3F0100 per beat, total 0xFC0400.
`ifdef NEURAL_SAT_EN
    run_vector("ovf_sat",  16'h0000, 16'h7F00, 16'h7F00, 16'h7FFF, 1'b1);
`else
    run_vector("ovf_wrap", 16'h0000, 16'h7F00, 16'h7F00, 16'h0400, 1'b1);
`endif
  endtask

  task automatic test_stall();
    do_start(16'h0100);
    for (int i = 0; i < 4; i++) begin
      send_beat(16'h0200, 16'h0100);
      if (i < 3) begin
        start = 1'b1;
        bias  = 16'h4000;
        @(negedge clk);
        start = 1'b0;
      end
    end
    for (int i = 0; i < 5; i++) begin
      start = i[0];
      bias  = 16'h4000;
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || out_sum !== 16'h0900 || out_fire !== 1'b1 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got valid=%b sum=%h fire=%b busy=%b want 1/0900/1/1",
                 i, out_valid, out_sum, out_fire, busy);
      end
    end
    start     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_release: busy got %b want 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    do_start(16'h1000);
    send_beat(16'h0100, 16'h0100);
    send_beat(16'h0100, 16'h0100);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, in_ready, out_valid, out_fire, out_sum} !== 20'h0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %h want 00000",
               {busy, in_ready, out_valid, out_fire, out_sum});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_vector("post_reset", 16'h0000, 16'h0100, 16'h0080, 16'h0200, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_vector("b2b_a", 16'h0300, 16'hFF00, 16'h0100, 16'hFF00, 1'b0);
    run_vector("b2b_b", 16'h0000, 16'h0180, 16'h0200, 16'h0C00, 1'b1);
  endtask

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    bias      = '0;
    in_valid  = 1'b0;
    in_x      = '0;
    in_w      = '0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
